// File: rtl/tspi_pkg.sv
// ---------------------------------------------------------------------------
// tspi_pkg : TSPI command opcodes and target state encoding
// Rev 1.0  : initial release
// ---------------------------------------------------------------------------
`default_nettype none

package tspi_pkg;

  localparam logic [7:0] TspiCmdWrite = 8'h02;
  localparam logic [7:0] TspiCmdRead  = 8'h03;
  localparam logic [7:0] TspiCmdId    = 8'h9F;

  typedef enum logic [2:0] {
    TspiIdle   = 3'd0,
    TspiCmd    = 3'd1,
    TspiAddr   = 3'd2,
    TspiWrite  = 3'd3,
    TspiRead   = 3'd4,
    TspiId     = 3'd5,
    TspiIgnore = 3'd6
  } tspi_tgt_state_e;

endpackage

`default_nettype wire

// File: rtl/tspi_if.sv
// ---------------------------------------------------------------------------
// tspi_if : TSPI pin bundle (SPI mode 0) between host and target
// Rev 1.0 : initial release
// ---------------------------------------------------------------------------
`default_nettype none

interface tspi_if;
  logic sclk;
  logic cs_n;
  logic mosi;
  logic miso;

  modport master (output sclk, output cs_n, output mosi, input miso);
  modport slave  (input sclk, input cs_n, input mosi, output miso);
endinterface

`default_nettype wire

// File: rtl/tspi_sync.sv
// ---------------------------------------------------------------------------
// tspi_sync : 2-FF synchronizer with optional rise/fall pulse outputs
// Rev 1.0   : initial release
// ---------------------------------------------------------------------------
`default_nettype none

module tspi_sync #(
  parameter bit EDGES     = 1'b0,
  parameter bit RESET_VAL = 1'b0
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o,
  output logic rise_o,
  output logic fall_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

  generate
    if (EDGES) begin : g_edges
      logic prev_q;
      always_ff @(posedge clk_i) begin
        if (rst_i) prev_q <= RESET_VAL;
        else       prev_q <= sync_q;
      end
      assign rise_o = sync_q & ~prev_q;
      assign fall_o = ~sync_q & prev_q;
    end else begin : g_no_edges
      assign rise_o = 1'b0;
      assign fall_o = 1'b0;
    end
  endgenerate

endmodule

`default_nettype wire

// File: rtl/tspi_target.sv
// ---------------------------------------------------------------------------
// tspi_target : SPI mode-0 target serving a byte-addressed register memory
// Rev 1.0     : initial release
// ---------------------------------------------------------------------------
`default_nettype none

module tspi_target
  import tspi_pkg::*;
#(
  parameter int         Depth     = 16,
  parameter logic [7:0] IdByte    = 8'hC5,
  parameter int         AddrWidth = $clog2(Depth)
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  tspi_if.slave                tspi,
  output logic                 busy_o,
  input  logic [AddrWidth-1:0] host_addr_i,
  output logic [7:0]           host_rdata_o
);

  logic sclk_rise, sclk_fall, cs_n_s, mosi_s;
  logic [3:0] unused_edges;

  tspi_sync #(.EDGES(1'b1), .RESET_VAL(1'b0)) u_sync_sclk (
    .clk_i(clk_i), .rst_i(rst_i), .d_i(tspi.sclk),
    .q_o(unused_edges[0]), .rise_o(sclk_rise), .fall_o(sclk_fall));

  // CS resets to "asserted" so a CS held low across reset never looks like a new frame.
  tspi_sync #(.EDGES(1'b0), .RESET_VAL(1'b0)) u_sync_cs (
    .clk_i(clk_i), .rst_i(rst_i), .d_i(tspi.cs_n),
    .q_o(cs_n_s), .rise_o(unused_edges[1]), .fall_o(unused_edges[2]));

  tspi_sync #(.EDGES(1'b0), .RESET_VAL(1'b0)) u_sync_mosi (
    .clk_i(clk_i), .rst_i(rst_i), .d_i(tspi.mosi),
    .q_o(mosi_s), .rise_o(unused_edges[3]), .fall_o());

  tspi_tgt_state_e      state_q, state_d;
  logic [2:0]           bit_cnt_q, bit_cnt_d;
  logic [6:0]           rx_sh_q, rx_sh_d;
  logic [7:0]           tx_sh_q, tx_sh_d;
  logic [AddrWidth-1:0] addr_q, addr_d;
  logic                 is_write_q, is_write_d;
  logic                 miso_q, miso_d;
  logic                 cs_prev_q, cs_prev_d;
  logic                 armed_q, armed_d;
  logic [7:0]           mem_q [Depth];
  logic [7:0]           mem_d [Depth];

  logic [7:0]           rx_byte;
  logic [AddrWidth-1:0] addr_inc;

  // Only 7 bits are stored: the 8th bit is merged straight from MOSI on completion.
  assign rx_byte  = {rx_sh_q, mosi_s};
  assign addr_inc = addr_q + AddrWidth'(1);

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    rx_sh_d    = rx_sh_q;
    tx_sh_d    = tx_sh_q;
    addr_d     = addr_q;
    is_write_d = is_write_q;
    miso_d     = miso_q;
    mem_d      = mem_q;
    cs_prev_d  = cs_n_s;
    armed_d    = armed_q | cs_n_s;

    if (!(state_q == TspiRead || state_q == TspiId)) miso_d = 1'b0;

    if (cs_n_s) begin
      state_d   = TspiIdle;
      bit_cnt_d = '0;
      miso_d    = 1'b0;
    end else if (state_q == TspiIdle) begin
      if (armed_q && cs_prev_q) begin
        state_d   = TspiCmd;
        bit_cnt_d = '0;
      end
    end else if (sclk_rise) begin
      rx_sh_d   = rx_byte[6:0];
      bit_cnt_d = bit_cnt_q + 3'd1;
      if (bit_cnt_q == 3'd7) begin
        case (state_q)
          TspiCmd: begin
            if (rx_byte == TspiCmdWrite || rx_byte == TspiCmdRead) begin
              state_d    = TspiAddr;
              is_write_d = (rx_byte == TspiCmdWrite);
            end else if (rx_byte == TspiCmdId) begin
              state_d = TspiId;
              tx_sh_d = IdByte;
            end else begin
              state_d = TspiIgnore;
            end
          end
          TspiAddr: begin
            addr_d = rx_byte[AddrWidth-1:0];
            if (is_write_q) begin
              state_d = TspiWrite;
            end else begin
              state_d = TspiRead;
              tx_sh_d = mem_q[rx_byte[AddrWidth-1:0]];
            end
          end
          TspiWrite: begin
            mem_d[addr_q] = rx_byte;
            addr_d        = addr_inc;
          end
          TspiRead: begin
            addr_d  = addr_inc;
            tx_sh_d = mem_q[addr_inc];
          end
          TspiId:  tx_sh_d = IdByte;
          default: ;
        endcase
      end
    end else if (sclk_fall && (state_q == TspiRead || state_q == TspiId)) begin
      miso_d  = tx_sh_q[7];
      tx_sh_d = {tx_sh_q[6:0], 1'b0};
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= TspiIdle;
      bit_cnt_q  <= '0;
      rx_sh_q    <= '0;
      tx_sh_q    <= '0;
      addr_q     <= '0;
      is_write_q <= 1'b0;
      miso_q     <= 1'b0;
      cs_prev_q  <= 1'b0;
      armed_q    <= 1'b0;
      for (int i = 0; i < Depth; i++) mem_q[i] <= 8'h00;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      rx_sh_q    <= rx_sh_d;
      tx_sh_q    <= tx_sh_d;
      addr_q     <= addr_d;
      is_write_q <= is_write_d;
      miso_q     <= miso_d;
      cs_prev_q  <= cs_prev_d;
      armed_q    <= armed_d;
      mem_q      <= mem_d;
    end
  end

  assign tspi.miso    = miso_q;
  assign busy_o       = ~cs_n_s & armed_q;
  assign host_rdata_o = mem_q[host_addr_i];

endmodule

`default_nettype wire

// File: tb/tb_tspi_target.sv
// ---------------------------------------------------------------------------
// tb_tspi_target : directed + random SPI transactions against a memory model
// Rev 1.0        : initial release
// ---------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module tb_tspi_target;

  localparam int DEPTH = 16;
  localparam int HALF  = 80;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] host_addr;
  logic [7:0] host_rdata;
  logic       busy;

  tspi_if bus();

  tspi_target #(.Depth(DEPTH), .IdByte(8'hC5)) dut (
    .clk_i(clk), .rst_i(rst), .tspi(bus), .busy_o(busy),
    .host_addr_i(host_addr), .host_rdata_o(host_rdata));

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  logic [7:0] model_mem [DEPTH];
  logic [7:0] txb [16];
  logic [7:0] rxb [16];
  logic [7:0] expb [16];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic spi_bits(input logic [7:0] b, input int nbits, output logic [7:0] r);
    r = 8'h00;
    for (int i = 0; i < nbits; i++) begin
      bus.mosi = b[7-i];
      #HALF;
      r = {r[6:0], bus.miso};
      bus.sclk = 1'b1;
      #HALF;
      bus.sclk = 1'b0;
    end
  endtask

  task automatic cs_assert();
    bus.cs_n = 1'b0;
    #HALF;
  endtask

  task automatic cs_release();
    #HALF;
    bus.cs_n = 1'b1;
    #120;
  endtask

  // Expected MISO bytes from the protocol rules; also applies writes to the model.
  task automatic run_model(input int n);
    int a;
    for (int i = 0; i < 16; i++) expb[i] = 8'h00;
    if (txb[0] == 8'h9F) begin
      for (int i = 1; i < n; i++) expb[i] = 8'hC5;
    end else if (txb[0] == 8'h02 || txb[0] == 8'h03) begin
      a = int'(txb[1]) % DEPTH;
      for (int i = 2; i < n; i++) begin
        if (txb[0] == 8'h03) expb[i] = model_mem[(a + i - 2) % DEPTH];
        else                 model_mem[(a + i - 2) % DEPTH] = txb[i];
      end
    end
  endtask

  task automatic xfer_check(input int n, input string tag);
    run_model(n);
    cs_assert();
    for (int i = 0; i < n; i++) spi_bits(txb[i], 8, rxb[i]);
    cs_release();
    for (int i = 0; i < n; i++) check($sformatf("%s_b%0d", tag, i), rxb[i], expb[i]);
  endtask

  task automatic check_mem(input string tag);
    for (int a = 0; a < DEPTH; a++) begin
      host_addr = 4'(a);
      #1;
      check($sformatf("%s_m%0d", tag, a), host_rdata, model_mem[a]);
      #4;
    end
  endtask

  initial begin
    logic [7:0] r;
    int a, len;
    bus.sclk = 1'b0; bus.cs_n = 1'b1; bus.mosi = 1'b0; host_addr = '0;
    for (int i = 0; i < DEPTH; i++) model_mem[i] = 8'h00;
    #2;
    rst = 1'b1;
    #40;
    rst = 1'b0;
    #50;
    check("rst_miso", bus.miso, 1'b0);
    check("rst_busy", busy, 1'b0);
    check_mem("rst");

    // ID read with busy observation
    cs_assert();
    spi_bits(8'h9F, 8, rxb[0]);
    check("id_busy_hi", busy, 1'b1);
    spi_bits(8'h00, 8, rxb[1]);
    spi_bits(8'h00, 8, rxb[2]);
    cs_release();
    check("id_busy_lo", busy, 1'b0);
    check("id_cmd_miso", rxb[0], 8'h00);
    check("id_b1", rxb[1], 8'hC5);
    check("id_b2", rxb[2], 8'hC5);

    // Mid-byte abort leaves mem[5] untouched
    cs_assert();
    spi_bits(8'h02, 8, r);
    spi_bits(8'h05, 8, r);
    spi_bits(8'hFF, 5, r);
    cs_release();
    host_addr = 4'd5; #1;
    check("abort_mem5", host_rdata, 8'h00);
    txb[0] = 8'h03; txb[1] = 8'h05; txb[2] = 8'h00;
    xfer_check(3, "abort_rd");

    // CS rising together with the 8th SCLK rise drops the byte
    cs_assert();
    spi_bits(8'h02, 8, r);
    spi_bits(8'h06, 8, r);
    spi_bits(8'hA5, 7, r);
    bus.mosi = 1'b1;
    #HALF;
    bus.sclk = 1'b1; bus.cs_n = 1'b1;
    #HALF;
    bus.sclk = 1'b0;
    #120;
    host_addr = 4'd6; #1;
    check("simul_mem6", host_rdata, 8'h00);

    // Write then read back
    txb[0] = 8'h02; txb[1] = 8'h03; txb[2] = 8'hAA; txb[3] = 8'hBB; txb[4] = 8'hCC;
    xfer_check(5, "wr");
    txb[0] = 8'h03; txb[1] = 8'h03; txb[2] = 8'h00; txb[3] = 8'h00; txb[4] = 8'h00;
    xfer_check(5, "rd");
    host_addr = 4'd4; #1;
    check("host_rd4", host_rdata, 8'hBB);

    // Address wrap and ignored upper address bits
    txb[0] = 8'h02; txb[1] = 8'h0F; txb[2] = 8'h11; txb[3] = 8'h22;
    xfer_check(4, "wrap_wr");
    check_mem("wrap");
    txb[0] = 8'h03; txb[1] = 8'hFF; txb[2] = 8'h00; txb[3] = 8'h00;
    xfer_check(4, "wrap_rd");

    // Unknown command
    txb[0] = 8'h7E; txb[1] = 8'h12; txb[2] = 8'h34;
    xfer_check(3, "ign");
    check_mem("ign");

    // Random writes and reads
    for (int k = 0; k < 6; k++) begin
      a = $urandom_range(0, 255); len = $urandom_range(1, 4);
      txb[0] = 8'h02; txb[1] = 8'(a);
      for (int i = 0; i < len; i++) txb[2+i] = 8'($urandom_range(0, 255));
      xfer_check(len + 2, $sformatf("rnd_wr%0d", k));
      a = $urandom_range(0, 255); len = $urandom_range(1, 5);
      txb[0] = 8'h03; txb[1] = 8'(a);
      for (int i = 0; i < len; i++) txb[2+i] = 8'($urandom_range(0, 255));
      xfer_check(len + 2, $sformatf("rnd_rd%0d", k));
    end
    check_mem("rnd");

    // Reset during a READ; bits clocked afterwards under the same CS are ignored
    cs_assert();
    spi_bits(8'h03, 8, r);
    spi_bits(8'h00, 8, r);
    spi_bits(8'h00, 3, r);
    #20;
    rst = 1'b1;
    #30;
    rst = 1'b0;
    #20;
    check("rst_rd_miso", bus.miso, 1'b0);
    for (int i = 0; i < DEPTH; i++) model_mem[i] = 8'h00;
    spi_bits(8'h02, 8, r); check("post_rst_b0", r, 8'h00);
    spi_bits(8'h00, 8, r); check("post_rst_b1", r, 8'h00);
    spi_bits(8'h55, 8, r); check("post_rst_b2", r, 8'h00);
    cs_release();
    check_mem("post_rst");
    txb[0] = 8'h02; txb[1] = 8'h01; txb[2] = 8'h5A;
    xfer_check(3, "fresh_wr");
    txb[0] = 8'h03; txb[1] = 8'h01; txb[2] = 8'h00;
    xfer_check(3, "fresh_rd");
    check_mem("final");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
